// File: rtl/gold_pkg.sv
// Shared types and constants for the gold-bag support scan.
package gold_pkg;

  typedef enum logic [3:0] {
    GOLD_IDLE    = 4'd0,
    GOLD_FALLING = 4'd1,
    GOLD_CRASHED = 4'd2,
    GOLD_EATEN   = 4'd3
  } gold_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_REQ,
    S_EVAL
  } scan_state_e;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned XOFF_BASE = 4;
  localparam int unsigned XOFF_STEP = 8;

  // Sample points sit at the centre of each 8-px slice of the bag's bottom edge.
  function automatic logic signed [11:0] sample_xoff(input int unsigned idx);
    return 12'(XOFF_BASE + XOFF_STEP * idx);
  endfunction

endpackage

// File: rtl/gold_sample_addr.sv
// Combinational sample-point address and range classification for one idx.
module gold_sample_addr
  import gold_pkg::*;
#(
  parameter int unsigned CELL_SIZE     = 32,
  parameter int unsigned MAP_SHIFT     = 2,
  parameter int unsigned SCREEN_BOTTOM = 480,
  parameter int unsigned IDX_W         = 3
) (
  input  logic [10:0]      i_x,
  input  logic [10:0]      i_y,
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_rd_x,
  output logic [6:0]       o_rd_y,
  output logic             o_above_top,
  output logic             o_below_floor,
  output logic             o_off_side
);

  localparam logic signed [11:0] W_CELL = 12'(CELL_SIZE);
  localparam logic signed [11:0] W_BOT  = 12'(SCREEN_BOTTOM);
  localparam logic signed [11:0] W_SCR  = 12'(SCREEN_W);

  logic signed [11:0] w_sx;
  logic signed [11:0] w_sy;
  logic               w_unused;

  // Widen to 12 bits first so a bag near the 11-bit limit cannot wrap negative.
  assign w_sx = $signed({i_x[10], i_x}) + sample_xoff(32'(i_idx));
  assign w_sy = $signed({i_y[10], i_y}) + W_CELL;

  assign o_above_top   = w_sy[11];
  assign o_below_floor = (w_sy >= W_BOT);
  assign o_off_side    = w_sx[11] || (w_sx >= W_SCR);

  assign o_rd_x = w_sx[MAP_SHIFT +: 8];
  assign o_rd_y = w_sy[MAP_SHIFT +: 7];

  assign w_unused = ^{w_sx, w_sy};

endmodule

// File: rtl/gold_support_detect.sv
// Per-frame dirt-support scan under a gold bag; drives can_fall.
// Optional GOLD_SUPPORT_DEBOUNCE_EN: can_fall rises only after two empty scans in a row.
module gold_support_detect
  import gold_pkg::*;
#(
  parameter int unsigned CELL_SIZE     = 32,
  parameter int unsigned MAP_SHIFT     = 2,
  parameter int unsigned SAMPLE_POINTS = 4,
  parameter int unsigned SCREEN_BOTTOM = 480
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic [3:0]  gold_state,
  output logic        rd_req,
  output logic [7:0]  rd_x,
  output logic [6:0]  rd_y,
  input  logic        rd_ack,
  input  logic        rd_data,
  output logic        can_fall,
  output logic        scan_done,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(SAMPLE_POINTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_POINTS - 1);

  scan_state_e      r_state, w_state_nxt;
  logic [10:0]      r_x, r_y, r_px, r_py;
  logic [3:0]       r_gs, r_pgs;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_empty, w_empty_nxt;
  logic             r_restart, w_restart_nxt;
  logic             r_can_fall, r_scan_done;
`ifdef GOLD_SUPPORT_DEBOUNCE_EN
  logic             r_streak;
`endif

  logic       w_rd_req, w_advance, w_load, w_load_pend, w_apply_pend, w_update, w_skip;
  logic [7:0] w_ax;
  logic [6:0] w_ay;
  logic       w_above_top, w_below_floor, w_off_side;

  gold_sample_addr #(
    .CELL_SIZE    (CELL_SIZE),
    .MAP_SHIFT    (MAP_SHIFT),
    .SCREEN_BOTTOM(SCREEN_BOTTOM),
    .IDX_W        (IDX_W)
  ) u_addr (
    .i_x          (r_x),
    .i_y          (r_y),
    .i_idx        (r_idx),
    .o_rd_x       (w_ax),
    .o_rd_y       (w_ay),
    .o_above_top  (w_above_top),
    .o_below_floor(w_below_floor),
    .o_off_side   (w_off_side)
  );

  assign w_skip = (r_gs == GOLD_CRASHED) || (r_gs == GOLD_EATEN);

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_empty_nxt   = r_empty;
    w_restart_nxt = r_restart;
    w_rd_req      = 1'b0;
    w_advance     = 1'b0;
    w_load        = 1'b0;
    w_load_pend   = 1'b0;
    w_apply_pend  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (startOfFrame) begin
          w_load      = 1'b1;
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_idx_nxt = '0;
        if (w_skip) begin
          w_empty_nxt = 1'b0;
          w_state_nxt = S_EVAL;
        end else begin
          w_empty_nxt = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_above_top) begin
          w_advance = 1'b1;
        end else if (w_below_floor || w_off_side) begin
          w_advance   = 1'b1;
          w_empty_nxt = 1'b0;
        end else begin
          w_rd_req = 1'b1;
          if (rd_ack) begin
            w_advance   = 1'b1;
            w_empty_nxt = r_empty & ~rd_data;
          end
        end
        if (w_advance) begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_restart) begin
            w_apply_pend  = 1'b1;
            w_restart_nxt = 1'b0;
            w_state_nxt   = S_LATCH;
          end else if (r_idx == LAST_IDX) begin
            w_state_nxt = S_EVAL;
          end
        end
      end
      S_EVAL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A new frame mid-scan waits out an unacked read, then restarts from the parked coordinates.
    if (startOfFrame && (r_state != S_IDLE)) begin
      if (w_rd_req && !rd_ack) begin
        w_load_pend   = 1'b1;
        w_restart_nxt = 1'b1;
      end else begin
        w_load        = 1'b1;
        w_apply_pend  = 1'b0;
        w_restart_nxt = 1'b0;
        w_state_nxt   = S_LATCH;
      end
    end
  end

  // Result registers load on entry to EVAL so they are visible during the EVAL cycle.
  assign w_update = (w_state_nxt == S_EVAL);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_gs      <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_pgs     <= '0;
      r_idx     <= '0;
      r_empty   <= 1'b1;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_empty   <= w_empty_nxt;
      r_restart <= w_restart_nxt;
      if (w_load) begin
        r_x  <= topLeftX;
        r_y  <= topLeftY;
        r_gs <= gold_state;
      end else if (w_apply_pend) begin
        r_x  <= r_px;
        r_y  <= r_py;
        r_gs <= r_pgs;
      end
      if (w_load_pend) begin
        r_px  <= topLeftX;
        r_py  <= topLeftY;
        r_pgs <= gold_state;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_can_fall  <= 1'b0;
      r_scan_done <= 1'b0;
`ifdef GOLD_SUPPORT_DEBOUNCE_EN
      r_streak    <= 1'b0;
`endif
    end else begin
      r_scan_done <= w_update;
      if (w_update) begin
`ifdef GOLD_SUPPORT_DEBOUNCE_EN
        r_can_fall <= w_empty_nxt & r_streak;
        r_streak   <= w_empty_nxt;
`else
        r_can_fall <= w_empty_nxt;
`endif
      end
    end
  end

  assign rd_req    = w_rd_req;
  assign rd_x      = w_rd_req ? w_ax : '0;
  assign rd_y      = w_rd_req ? w_ay : '0;
  assign can_fall  = r_can_fall;
  assign scan_done = r_scan_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gold_support_detect.sv
// Self-checking bench for gold_support_detect: directed cases plus randomized frames.
module tb_gold_support_detect;

`ifdef GOLD_SUPPORT_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] topLeftX = '0;
  logic [10:0] topLeftY = '0;
  logic [3:0]  gold_state = '0;
  logic        rd_req;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic        rd_ack = 1'b0;
  logic        rd_data = 1'b0;
  logic        can_fall, scan_done, busy;

  gold_support_detect dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .topLeftX    (topLeftX),
    .topLeftY    (topLeftY),
    .gold_state  (gold_state),
    .rd_req      (rd_req),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .can_fall    (can_fall),
    .scan_done   (scan_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          dirt [0:255][0:127];
  int          ack_delay = 0;
  int          unstable = 0;
  int          done_cnt = 0;
  int          req_cycles = 0;
  logic [14:0] reads[$];
  logic [14:0] exp_q[$];
  int          m_cnt = 0;
  bit          m_can = 1'b0;

  // Dirt-map responder: acks after ack_delay wait cycles and watches address stability.
  bit         pending = 1'b0;
  int         wcnt = 0;
  logic [7:0] hold_x;
  logic [6:0] hold_y;
  always @(negedge clk) begin
    if (rd_ack) begin
      rd_ack  = 1'b0;
      pending = 1'b0;
    end
    if (rd_req === 1'b1) begin
      if (!pending) begin
        pending = 1'b1;
        wcnt    = 0;
        hold_x  = rd_x;
        hold_y  = rd_y;
      end else if (rd_x !== hold_x || rd_y !== hold_y) begin
        unstable++;
      end
      if (wcnt >= ack_delay) begin
        rd_ack  = 1'b1;
        rd_data = dirt[rd_x][rd_y];
      end else begin
        wcnt++;
      end
    end else begin
      pending = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (resetN) begin
      if (rd_req && rd_ack) reads.push_back({rd_x, rd_y});
      if (rd_req) req_cycles++;
      if (scan_done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: classify each sample point straight from the pixel-space rules.
  task automatic model_scan(input int x, input int y, input int gs, output bit empty);
    int sx, sy;
    exp_q.delete();
    empty = 1'b1;
    if (gs == 2 || gs == 3) begin
      empty = 1'b0;
      return;
    end
    sy = y + 32;
    for (int i = 0; i < 4; i++) begin
      sx = x + 4 + 8 * i;
      if (sy < 0) continue;
      if (sy >= 480 || sx < 0 || sx > 639) begin
        empty = 1'b0;
        continue;
      end
      exp_q.push_back({8'(sx / 4), 7'(sy / 4)});
      if (dirt[sx / 4][sy / 4]) empty = 1'b0;
    end
  endtask

  task automatic model_commit(input bit empty);
    m_cnt = empty ? m_cnt + 1 : 0;
    m_can = empty && (!DEB || m_cnt >= 2);
  endtask

  task automatic clear_dirt();
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 128; b++) dirt[a][b] = 1'b0;
  endtask

  task automatic start_frame(input int x, input int y, input int gs);
    @(negedge clk);
    topLeftX     = 11'(x);
    topLeftY     = 11'(y);
    gold_state   = 4'(gs);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic run_frame(input int x, input int y, input int gs, input int dly, output int lat);
    bit empty;
    int d0;
    ack_delay = dly;
    model_scan(x, y, gs, empty);
    reads.delete();
    d0 = done_cnt;
    start_frame(x, y, gs);
    chk("busy_cycle1", busy, 1);
    lat = 1;
    while (scan_done !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("scan_done_seen", scan_done, 1);
    model_commit(empty);
    chk("can_fall", can_fall, m_can);
    chk("num_reads", reads.size(), exp_q.size());
    foreach (exp_q[k])
      if (k < reads.size()) chk("read_addr", reads[k], exp_q[k]);
    repeat (2) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("idle_busy", busy, 0);
    chk("can_fall_held", can_fall, m_can);
  endtask

  initial begin
    int lat, n, d0, r0;
    bit empty, held;
    int rx, ry, rg;

    clear_dirt();
    #1;
    chk("rst_can_fall", can_fall, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_x", rd_x, 0);
    chk("rst_rd_y", rd_y, 0);
    @(negedge clk);
    resetN = 1'b1;

    // Flat ground with no dirt: four reads on row 48, latency 6.
    run_frame(32, 160, 0, 0, lat);
    chk("t2_latency", lat, 6);
    chk("t2_can_fall_first", can_fall, DEB ? 0 : 1);
    chk("t2_nreads", reads.size(), 4);
    if (reads.size() == 4) begin
      chk("t2_rd0", reads[0], {8'd9, 7'd48});
      chk("t2_rd1", reads[1], {8'd11, 7'd48});
      chk("t2_rd2", reads[2], {8'd13, 7'd48});
      chk("t2_rd3", reads[3], {8'd15, 7'd48});
    end
    run_frame(32, 160, 0, 0, lat);
    chk("t2_can_fall_second", can_fall, 1);

    // Reset while a read is outstanding.
    ack_delay = 3;
    start_frame(32, 160, 0);
    n = 0;
    while (rd_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t1_req_seen", rd_req, 1);
    resetN = 1'b0;
    #1;
    chk("t1_rd_req", rd_req, 0);
    chk("t1_rd_x", rd_x, 0);
    chk("t1_rd_y", rd_y, 0);
    chk("t1_can_fall", can_fall, 0);
    chk("t1_busy", busy, 0);
    chk("t1_scan_done", scan_done, 0);
    m_cnt = 0;
    m_can = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    r0 = req_cycles;
    repeat (10) @(negedge clk);
    chk("t1_no_req_after", req_cycles - r0, 0);

    // One dirt bit under the third sample point.
    dirt[13][48] = 1'b1;
    run_frame(32, 160, 0, 0, lat);
    chk("t3_can_fall", can_fall, 0);
    unstable = 0;
    run_frame(32, 160, 0, 3, lat);
    chk("t3_can_fall_slow", can_fall, 0);
    chk("t3_addr_stable", unstable, 0);
    clear_dirt();

    // Debounce: after a supported frame, one empty frame is not enough when enabled.
    run_frame(32, 160, 0, 1, lat);
    chk("deb_first_empty", can_fall, DEB ? 0 : 1);
    run_frame(32, 160, 0, 1, lat);
    chk("deb_second_empty", can_fall, 1);

    // Floor, above the top of the screen, and the 12-bit no-wrap case.
    run_frame(32, 448, 0, 0, lat);
    chk("t4_floor_reads", reads.size(), 0);
    chk("t4_floor_can_fall", can_fall, 0);
    run_frame(32, -40, 0, 0, lat);
    chk("t4_top_reads", reads.size(), 0);
    run_frame(32, 1023, 1, 0, lat);
    chk("t4_nowrap_can_fall", can_fall, 0);
    run_frame(620, 100, 0, 0, lat);

    // Crashed bag over empty dirt: skipped, never falls.
    run_frame(32, 160, 2, 0, lat);
    chk("t5_reads", reads.size(), 0);
    chk("t5_can_fall", can_fall, 0);
    run_frame(32, 160, 3, 0, lat);

    // New frame during the second outstanding read.
    run_frame(32, 160, 0, 0, lat);
    run_frame(32, 160, 0, 0, lat);
    ack_delay = 3;
    reads.delete();
    d0 = done_cnt;
    unstable = 0;
    start_frame(32, 160, 0);
    n = 0;
    while (!(reads.size() == 1 && rd_req === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_second_read_pending", reads.size(), 1);
    dirt[28][58] = 1'b1;
    model_scan(100, 200, 0, empty);
    start_frame(100, 200, 0);
    held = 1'b1;
    n = 0;
    while (scan_done !== 1'b1 && n < 300) begin
      if (can_fall !== m_can) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("t6_done", scan_done, 1);
    chk("t6_can_fall_held", held, 1);
    model_commit(empty);
    chk("t6_can_fall", can_fall, m_can);
    chk("t6_nreads", reads.size(), 2 + exp_q.size());
    if (reads.size() > 1) chk("t6_discarded_addr", reads[1], {8'd11, 7'd48});
    foreach (exp_q[k])
      if (k + 2 < reads.size()) chk("t6_restart_addr", reads[k + 2], exp_q[k]);
    repeat (3) @(negedge clk);
    chk("t6_single_done", done_cnt - d0, 1);
    chk("t6_addr_stable", unstable, 0);
    clear_dirt();

    // Randomized frames against the reference model.
    unstable = 0;
    for (int f = 0; f < 40; f++) begin
      for (int a = 0; a < 256; a++)
        for (int b = 0; b < 128; b++) dirt[a][b] = ($urandom_range(0, 7) == 0);
      rx = $urandom_range(0, 720) - 40;
      ry = $urandom_range(0, 530) - 60;
      rg = ($urandom_range(0, 7) < 6) ? $urandom_range(0, 1) : $urandom_range(2, 3);
      if (f % 5 == 0) rx = 32;
      run_frame(rx, ry, rg, $urandom_range(0, 2), lat);
    end
    chk("rand_addr_stable", unstable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
